lock_detect: RTL and testbench
==============================

LOCK_DETECT -- requirements
Module: lock_detect

Interface
REQ-001 Parameter FREQ_TOL, default 1: max |cnt - divn| counted as a frequency-good sample.
REQ-002 Parameter PHASE_TOL, default 4: max |phase_err| counted as a phase-good sample.
REQ-003 Parameter LOCK_CNT, default 16: consecutive good samples required to advance state.
REQ-004 Parameter UNLOCK_CNT, default 4: consecutive bad phase samples that drop PHASE_LOCKED.
REQ-005 The block SHALL have one clock and SHALL use a synchronous, active-low reset.
REQ-006 refclk  in  1  sole clock; all logic on its rising edge.
REQ-007 resetn  in  1  synchronous active-low reset.
REQ-008 brake  in  1  supply-droop event; forces loss of lock.
REQ-009 divn  in  8  unsigned feedback divide ratio; expected pclk cycles per refclk period.
REQ-010 cnt_valid  in  1  single-cycle strobe qualifying cnt.
REQ-011 cnt  in  16  unsigned pclk cycles measured over the last refclk period.
REQ-012 phase_valid  in  1  single-cycle strobe qualifying phase_err.
REQ-013 phase_err  in  8  signed (two's complement) phase error sample.
REQ-014 lock_state  out  2  encoding: RESET=0, FREQ_SEARCH=1, FREQ_LOCKED=2, PHASE_LOCKED=3.
REQ-015 locked  out  1  high iff lock_state==PHASE_LOCKED.
REQ-016 freq_err  out  17  signed cnt - divn, zero-extended operands.

Function
REQ-017 All outputs SHALL be registered; lock_state changes on the cycle after the qualifying strobe.
REQ-018 freq_err SHALL update only on cnt_valid and hold otherwise.
REQ-019 Frequency-good: |cnt - divn| <= FREQ_TOL, computed in 17 bits; no wrap-around.
REQ-020 Phase-good: |phase_err| <= PHASE_TOL, computed in 9 bits; phase_err=-128 gives 128 (bad).
REQ-021 RESET: unconditionally -> FREQ_SEARCH on the first cycle with resetn high.
REQ-022 FREQ_SEARCH: each good cnt sample increments good_cnt; a bad sample clears it; reaching LOCK_CNT -> FREQ_LOCKED, good_cnt cleared.
REQ-023 FREQ_SEARCH SHALL ignore phase_valid.
REQ-024 FREQ_LOCKED: good phase increments good_cnt, bad phase clears it; reaching LOCK_CNT -> PHASE_LOCKED, counters cleared.
REQ-025 FREQ_LOCKED or PHASE_LOCKED: any bad cnt sample -> FREQ_SEARCH immediately, counters cleared.
REQ-026 PHASE_LOCKED: a bad phase increments bad_cnt, a good phase clears it; reaching UNLOCK_CNT -> FREQ_LOCKED, counters cleared.
REQ-027 Simultaneous cnt_valid and phase_valid: frequency failure takes priority; otherwise both samples are evaluated in the same cycle, frequency first.
REQ-028 brake high in any non-RESET state: next state FREQ_SEARCH, counters cleared, strobes in that cycle ignored; brake overrides all other events.
REQ-029 good_cnt and bad_cnt SHALL saturate at their thresholds, never wrap.
REQ-030 A divn change SHALL take effect on the next cnt_valid; no implicit state change.

Reset
REQ-031 While resetn low: lock_state=RESET, locked=0, freq_err=0, counters 0; reset overrides brake and strobes.
REQ-032 Reset asserted mid-lock SHALL return lock_state to RESET on the next edge.

Verification
REQ-033 divn=32, 16 cnt_valid with cnt=33 -> FREQ_LOCKED one cycle after the 16th strobe; freq_err=+1.
REQ-034 From FREQ_LOCKED, 15 phase_err=4 then one -5 then 16 of -4 -> PHASE_LOCKED only after the final 16; locked=1.
REQ-035 In PHASE_LOCKED, 3 phase_err=-128 then one 0 then 4 of 5 -> FREQ_LOCKED after the 4th consecutive bad sample.
REQ-036 In PHASE_LOCKED, cnt=30 with simultaneous good phase -> FREQ_SEARCH next cycle; freq_err=-2.
REQ-037 In PHASE_LOCKED, 1-cycle brake pulse with cnt_valid -> FREQ_SEARCH next cycle, locked=0.
REQ-038 resetn low for one cycle while PHASE_LOCKED -> RESET, then FREQ_SEARCH; 16 further good cnt needed to relock frequency.

Source files
------------

// File: rtl/lock_detect_if.sv
// Lock-detector bus: measurement strobes in, lock status out.
interface lock_detect_if;
  logic        brake;
  logic [7:0]  divn;
  logic        cnt_valid;
  logic [15:0] cnt;
  logic        phase_valid;
  logic [7:0]  phase_err;
  logic [1:0]  lock_state;
  logic        locked;
  logic [16:0] freq_err;

  modport master (
    output brake, divn, cnt_valid, cnt, phase_valid, phase_err,
    input  lock_state, locked, freq_err
  );

  modport slave (
    input  brake, divn, cnt_valid, cnt, phase_valid, phase_err,
    output lock_state, locked, freq_err
  );
endinterface

// File: rtl/lock_detect.sv
// PLL lock detector: qualifies frequency then phase samples and reports the
// lock state.
module lock_detect #(
  parameter int unsigned FREQ_TOL   = 1,
  parameter int unsigned PHASE_TOL  = 4,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic         refclk,
  input  logic         resetn,
  lock_detect_if.slave ld
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_RESET        = 2'd0,
    ST_FREQ_SEARCH  = 2'd1,
    ST_FREQ_LOCKED  = 2'd2,
    ST_PHASE_LOCKED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       good_cnt_q, good_cnt_d;
  logic [BW-1:0]       bad_cnt_q, bad_cnt_d;
  logic                locked_q, locked_d;
  logic [16:0]         freq_err_q, freq_err_d;

  logic [16:0]         fdiff_c;
  logic [16:0]         fabs_c;
  logic [8:0]          pext_c;
  logic [8:0]          pabs_c;
  logic                freq_good_c;
  logic                phase_good_c;
  logic                freq_fail_c;
  logic [GW-1:0]       good_inc_c;
  logic [BW-1:0]       bad_inc_c;

  // Magnitudes: the 17-bit difference cannot wrap since cnt < 2^16.
  assign fdiff_c      = {1'b0, ld.cnt} - {9'b0, ld.divn};
  assign fabs_c       = fdiff_c[16] ? (17'd0 - fdiff_c) : fdiff_c;
  assign freq_good_c  = fabs_c <= 17'(FREQ_TOL);
  assign pext_c       = {ld.phase_err[7], ld.phase_err};
  assign pabs_c       = pext_c[8] ? (9'd0 - pext_c) : pext_c;
  assign phase_good_c = pabs_c <= 9'(PHASE_TOL);

  assign freq_fail_c  = ld.cnt_valid && !freq_good_c;
  assign good_inc_c   = (good_cnt_q == GW'(LOCK_CNT))   ? good_cnt_q : good_cnt_q + GW'(1);
  assign bad_inc_c    = (bad_cnt_q  == BW'(UNLOCK_CNT)) ? bad_cnt_q  : bad_cnt_q  + BW'(1);

  // State and status registers.
  always_ff @(posedge refclk) begin
    if (!resetn) begin
      state_q    <= ST_RESET;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      freq_err_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      freq_err_q <= freq_err_d;
    end
  end

  // Next state; brake outranks a frequency failure, which outranks phase.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (state_q == ST_RESET) begin
      state_d = ST_FREQ_SEARCH;
    end else if (ld.brake || (freq_fail_c && state_q != ST_FREQ_SEARCH)) begin
      state_d    = ST_FREQ_SEARCH;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_FREQ_SEARCH: begin
          if (ld.cnt_valid) begin
            if (!freq_good_c) begin
              good_cnt_d = '0;
            end else if (good_inc_c == GW'(LOCK_CNT)) begin
              state_d    = ST_FREQ_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_inc_c;
            end
          end
        end
        ST_FREQ_LOCKED: begin
          if (ld.phase_valid) begin
            if (!phase_good_c) begin
              good_cnt_d = '0;
            end else if (good_inc_c == GW'(LOCK_CNT)) begin
              state_d    = ST_PHASE_LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_inc_c;
            end
          end
        end
        ST_PHASE_LOCKED: begin
          if (ld.phase_valid) begin
            if (phase_good_c) begin
              bad_cnt_d = '0;
            end else if (bad_inc_c == BW'(UNLOCK_CNT)) begin
              state_d    = ST_FREQ_LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              bad_cnt_d = bad_inc_c;
            end
          end
        end
        default: state_d = ST_FREQ_SEARCH;
      endcase
    end
  end

  // Status outputs; a braked cycle discards its cnt sample.
  always_comb begin
    locked_d   = (state_d == ST_PHASE_LOCKED);
    freq_err_d = freq_err_q;
    if (ld.cnt_valid && !(ld.brake && state_q != ST_RESET)) begin
      freq_err_d = fdiff_c;
    end
  end

  assign ld.lock_state = state_q;
  assign ld.locked     = locked_q;
  assign ld.freq_err   = freq_err_q;

endmodule

// File: tb/tb_lock_detect.sv
// Randomised and directed bench for lock_detect against an event-level model.
module tb_lock_detect;

  localparam int FT = 1;
  localparam int PT = 4;
  localparam int LC = 16;
  localparam int UC = 4;

  typedef struct packed {
    int st;
    int g;
    int b;
    int fe;
  } mst_t;

  logic refclk = 1'b0;
  logic resetn = 1'b0;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  mst_t m = '0;

  lock_detect_if bus ();

  lock_detect #(
    .FREQ_TOL  (FT),
    .PHASE_TOL (PT),
    .LOCK_CNT  (LC),
    .UNLOCK_CNT(UC)
  ) dut (
    .refclk(refclk),
    .resetn(resetn),
    .ld    (bus)
  );

  always #5 refclk = ~refclk;

  // Reference: one step of the lock rules per clock, on plain integers.
  function automatic mst_t step(mst_t cur, bit rn, bit br, bit cv, logic [15:0] c,
                                logic [7:0] dv, bit pv, logic [7:0] p);
    mst_t n = cur;
    int fe;
    int pe;
    bit fg;
    bit pg;
    if (!rn) return '0;
    fe = int'(c) - int'(dv);
    pe = int'($signed(p));
    fg = ((fe < 0) ? -fe : fe) <= FT;
    pg = ((pe < 0) ? -pe : pe) <= PT;
    if (cv && !(br && cur.st != 0)) n.fe = fe;
    if (cur.st == 0) begin
      n.st = 1;
    end else if (br || (cv && !fg && cur.st >= 2)) begin
      n.st = 1; n.g = 0; n.b = 0;
    end else if (cur.st == 1) begin
      if (cv) begin
        n.g = fg ? cur.g + 1 : 0;
        if (n.g >= LC) begin n.st = 2; n.g = 0; end
      end
    end else if (cur.st == 2) begin
      if (pv) begin
        n.g = pg ? cur.g + 1 : 0;
        if (n.g >= LC) begin n.st = 3; n.g = 0; n.b = 0; end
      end
    end else begin
      if (pv) begin
        n.b = pg ? 0 : cur.b + 1;
        if (n.b >= UC) begin n.st = 2; n.g = 0; n.b = 0; end
      end
    end
    return n;
  endfunction

  always @(posedge refclk)
    m <= step(m, resetn, bus.brake, bus.cnt_valid, bus.cnt, bus.divn,
              bus.phase_valid, bus.phase_err);

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge refclk) begin
    if (chk_en) begin
      check("model lock_state", int'(bus.lock_state), m.st);
      check("model locked", int'(bus.locked), (m.st == 3) ? 1 : 0);
      check("model freq_err", int'($signed(bus.freq_err)), m.fe);
    end
  end

  task automatic cyc(bit cv, int c, bit pv, int p, bit br);
    bus.cnt_valid   = cv;
    bus.phase_valid = pv;
    bus.brake       = br;
    if (cv) bus.cnt = 16'(c);
    if (pv) bus.phase_err = 8'(p);
    @(posedge refclk);
    #1;
    bus.cnt_valid   = 1'b0;
    bus.phase_valid = 1'b0;
    bus.brake       = 1'b0;
  endtask

  task automatic lock_all();
    bus.divn = 8'd32;
    for (int i = 0; i < LC; i++) cyc(1, 32, 0, 0, 0);
    for (int i = 0; i < LC; i++) cyc(0, 0, 1, 0, 0);
    check("relock state", int'(bus.lock_state), 3);
  endtask

  initial begin
    bus.brake = 0; bus.divn = 8'd32; bus.cnt_valid = 0; bus.cnt = '0;
    bus.phase_valid = 0; bus.phase_err = '0;
    resetn = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    chk_en = 1'b1;
    cyc(1, 100, 1, 100, 1);
    check("reset state", int'(bus.lock_state), 0);
    check("reset locked", int'(bus.locked), 0);
    check("reset freq_err", int'($signed(bus.freq_err)), 0);

    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("leave reset", int'(bus.lock_state), 1);

    for (int i = 0; i < LC; i++) begin
      cyc(1, 33, 1, 100, 0);
      if (i == LC - 2) check("15 good cnt", int'(bus.lock_state), 1);
    end
    check("freq locked", int'(bus.lock_state), 2);
    check("freq_err +1", int'($signed(bus.freq_err)), 1);

    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, -5, 0);
    check("phase -5 resets run", int'(bus.lock_state), 2);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, -4, 0);
    check("15 good phase", int'(bus.lock_state), 2);
    cyc(0, 0, 1, -4, 0);
    check("phase locked", int'(bus.lock_state), 3);
    check("locked high", int'(bus.locked), 1);

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, -128, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5, 0);
    check("3 bad phase", int'(bus.lock_state), 3);
    cyc(0, 0, 1, 5, 0);
    check("unlock phase", int'(bus.lock_state), 2);
    check("unlock locked", int'(bus.locked), 0);

    for (int i = 0; i < LC; i++) cyc(0, 0, 1, 0, 0);
    check("phase relock", int'(bus.lock_state), 3);
    cyc(1, 30, 1, 0, 0);
    check("freq fail", int'(bus.lock_state), 1);
    check("freq_err -2", int'($signed(bus.freq_err)), -2);

    lock_all();
    cyc(1, 32, 0, 0, 1);
    check("brake state", int'(bus.lock_state), 1);
    check("brake locked", int'(bus.locked), 0);

    lock_all();
    resetn = 1'b0;
    cyc(0, 0, 0, 0, 0);
    check("mid reset state", int'(bus.lock_state), 0);
    check("mid reset freq_err", int'($signed(bus.freq_err)), 0);
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("after reset", int'(bus.lock_state), 1);
    for (int i = 0; i < LC - 1; i++) cyc(1, 31, 0, 0, 0);
    check("15 after reset", int'(bus.lock_state), 1);
    cyc(1, 31, 0, 0, 0);
    check("relock freq", int'(bus.lock_state), 2);
    cyc(1, 34, 0, 0, 0);
    check("diff 2 bad", int'(bus.lock_state), 1);

    bus.divn = 8'd0;
    cyc(1, 65535, 0, 0, 0);
    check("max freq_err", int'($signed(bus.freq_err)), 65535);
    bus.divn = 8'd255;
    cyc(1, 0, 0, 0, 0);
    check("min freq_err", int'($signed(bus.freq_err)), -255);

    // Random segments alternating clean and noisy measurements.
    bus.divn = 8'd40;
    for (int seg = 0; seg < 20; seg++) begin
      int pgood = (seg % 2 == 0) ? 99 : 85;
      for (int k = 0; k < 200; k++) begin
        bit cv = ($urandom % 3) == 0;
        bit pv = ($urandom % 2) == 0;
        bit br = ($urandom % 400) == 0;
        int c;
        int p;
        if (($urandom % 600) == 0) bus.divn = 8'($urandom);
        if (int'($urandom % 100) < pgood) begin
          c = int'(bus.divn) + int'($urandom_range(0, 2)) - 1;
          if (c < 0) c = 0;
        end else begin
          case ($urandom % 4)
            0: c = 0;
            1: c = 65535;
            2: c = int'(bus.divn) + 2;
            default: c = int'($urandom % 65536);
          endcase
        end
        if (int'($urandom % 100) < pgood) p = int'($urandom_range(0, 8)) - 4;
        else p = int'($urandom % 256);
        resetn = ($urandom % 700) != 0;
        cyc(cv, c, pv, p, br);
      end
    end
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
